irq_btn_ctrl: RTL

- Receiving end of the board button/switch → interrupt path. The simulation bench currently drives this path as a raw one-cycle irq pulse.
- Synchronizes and debounces up to WIDTH external inputs (DIR_* buttons, SW*).
- Latches rising-edge events into pending bits.
- Drives the PacoBlaze3 `interrupt` line with an `interrupt_ack` handshake.
- Exposes level, pending, mask and clear registers on the processor port bus (INPUT/OUTPUT instructions).

---
 rtl/irq_btn_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/irq_btn_ctrl.sv
// rtl/irq_btn_ctrl.sv - button/switch debouncer and interrupt controller on the PacoBlaze3 port bus
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset (released synchronously by the board reset logic)
//   btn_in        raw asynchronous button/switch inputs, active high
//   port_id       processor port address
//   write_strobe  processor write qualifier (one cycle)
//   read_strobe   processor read qualifier; reads have no side effects so it is not needed
//   out_port      processor write data
//   in_port       registered read data (LEVEL, PENDING, MASK, else 0)
//   interrupt     interrupt request to the processor
//   interrupt_ack one-cycle acknowledge from the processor
//
// Register map at BASE_ADDR + offset: 0 LEVEL (ro), 1 PENDING (ro), 2 MASK (rw), 3 CLEAR (wo, W1C).

module irq_btn_ctrl #(
    parameter int         WIDTH           = 8,
    parameter int         DEBOUNCE_CYCLES = 320000,
    parameter int         CNT_W           = 19,
    parameter logic [7:0] BASE_ADDR       = 8'h10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_in,
    input  logic [7:0]       port_id,
    input  logic             write_strobe,
    input  logic             read_strobe,
    input  logic [7:0]       out_port,
    output logic [7:0]       in_port,
    output logic             interrupt,
    input  logic             interrupt_ack
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE
    } state_t;

    logic [WIDTH-1:0] sync1, sync2, samp, level, level_prev;
    logic [WIDTH-1:0] pending, mask;
    logic [WIDTH-1:0] stable, rise, wdata, clr_bits;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             sel, wr_mask, wr_clear, req;
    logic [7:0]       in_port_nxt;
    state_t           state, state_nxt;
    logic             unused_ok;

    assign unused_ok = ^{read_strobe, out_port};

    assign tick     = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign sel      = (port_id[7:2] == BASE_ADDR[7:2]);
    assign wr_mask  = write_strobe && sel && (port_id[1:0] == 2'd2);
    assign wr_clear = write_strobe && sel && (port_id[1:0] == 2'd3);
    assign wdata    = out_port[WIDTH-1:0];
    assign clr_bits = wr_clear ? wdata : '0;

    // A bit is accepted only when two consecutive ticks saw the same value.
    assign stable   = ~(sync2 ^ samp);
    assign rise     = level & ~level_prev;
    assign req      = |(pending & mask);

    // Synchronizer, prescaler and debounce
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            samp       <= '0;
            level      <= '0;
            level_prev <= '0;
            cnt        <= '0;
        end else begin
            sync1      <= btn_in;
            sync2      <= sync1;
            level_prev <= level;
            if (tick) begin
                cnt   <= '0;
                samp  <= sync2;
                level <= (level & ~stable) | (sync2 & stable);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Pending/mask registers; a rising edge beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= (pending & ~clr_bits) | rise;
            if (wr_mask) begin
                mask <= wdata;
            end
        end
    end

    // Read mux, registered every cycle regardless of read_strobe
    always_comb begin
        in_port_nxt = '0;
        if (sel) begin
            case (port_id[1:0])
                2'd0:    in_port_nxt[WIDTH-1:0] = level;
                2'd1:    in_port_nxt[WIDTH-1:0] = pending;
                2'd2:    in_port_nxt[WIDTH-1:0] = mask;
                default: in_port_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_port <= '0;
        end else begin
            in_port <= in_port_nxt;
        end
    end

    // Interrupt handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // In REQ only the ack matters, so an ack coincident with a CLEAR write
    // still lands in SERVICE. SERVICE is left only by a CLEAR write.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (req)           state_nxt = ST_REQ;
            ST_REQ:     if (interrupt_ack) state_nxt = ST_SERVICE;
            ST_SERVICE: if (wr_clear)      state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    assign interrupt = (state == ST_REQ);

endmodule
